// File: rtl/conv_pool_engine.sv
// Sequential 5x5 valid convolution + 2x2 max-pool over NUM_CH kernels, one MAC tap per cycle.
// Optional ReLU before pooling is enabled by defining CONV_RELU_EN.
module conv_pool_engine #(
  parameter int FRAC_BITS = 16,
  parameter int NUM_CH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [27:0][27:0][31:0]   data_i,
  input  logic [5:0][5:0][31:0]     kernel_i,
  output logic [2:0]                ch_sel_o,
  output logic [31:0]               out_data_o,
  output logic [10:0]               out_idx_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_CMP, S_OUT, S_DONE} state_e;
  localparam logic [10:0] LAST = 11'(NUM_CH * 144 - 1);
  localparam logic [31:0] MAX_INIT = 32'h8000_0000;

  state_e state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [3:0]  pr_q, pr_d, pc_q, pc_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  kr_q, kr_d, kc_q, kc_d;
  logic signed [63:0] acc_q, acc_d;
  logic [31:0] max_q, max_d;

  logic [4:0]  row, col;
  logic [31:0] pix, w;
  logic signed [64:0] prod;
  logic signed [63:0] sh;
  logic [31:0] v;
  logic [10:0] idx;
  logic        tap_last, hs, last;
  logic        unused_k;

  assign unused_k = ^{kernel_i[5], kernel_i[4][5], kernel_i[3][5], kernel_i[2][5],
                      kernel_i[1][5], kernel_i[0][5]};

  assign row  = {pr_q, 1'b0} + 5'(q_q[1]) + 5'(kr_q);
  assign col  = {pc_q, 1'b0} + 5'(q_q[0]) + 5'(kc_q);
  assign pix  = data_i[row][col];
  assign w    = kernel_i[kr_q][kc_q];
  // Pixels are unsigned: zero-extend to 33 bits so the product stays signed-correct.
  assign prod = $signed({1'b0, pix}) * $signed(w);
  assign sh   = acc_q >>> FRAC_BITS;

  always_comb begin
    if (sh > 64'sd2147483647)        v = 32'h7FFF_FFFF;
    else if (sh < -64'sd2147483648)  v = 32'h8000_0000;
    else                             v = sh[31:0];
`ifdef CONV_RELU_EN
    if (v[31]) v = '0;
`endif
  end

  assign idx      = 11'(ch_q) * 11'd144 + 11'(pr_q) * 11'd12 + 11'(pc_q);
  assign tap_last = (kr_q == 3'd4) && (kc_q == 3'd4);
  assign hs       = (state_q == S_OUT) && out_ready_i;
  assign last     = (idx == LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_MAC;
      S_MAC:  if (tap_last) state_d = S_CMP;
      S_CMP:  state_d = (q_q == 2'd3) ? S_OUT : S_MAC;
      S_OUT:  if (out_ready_i) state_d = last ? S_DONE : S_MAC;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid_o = (state_q == S_OUT);
    out_data_o  = (state_q == S_OUT) ? max_q : '0;
    out_idx_o   = idx;
    ch_sel_o    = ch_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    ch_d  = ch_q;  pr_d = pr_q;  pc_d = pc_q;  q_d = q_q;
    kr_d  = kr_q;  kc_d = kc_q;  acc_d = acc_q; max_d = max_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        ch_d = '0; pr_d = '0; pc_d = '0; q_d = '0; kr_d = '0; kc_d = '0;
        acc_d = '0; max_d = MAX_INIT;
      end
      S_MAC: begin
        acc_d = acc_q + prod[63:0];
        if (kc_q == 3'd4) begin
          kc_d = '0;
          kr_d = tap_last ? 3'd0 : kr_q + 3'd1;
        end else kc_d = kc_q + 3'd1;
      end
      S_CMP: begin
        if ($signed(v) > $signed(max_q)) max_d = v;
        acc_d = '0; kr_d = '0; kc_d = '0;
        if (q_q != 2'd3) q_d = q_q + 2'd1;
      end
      S_OUT: if (hs) begin
        max_d = MAX_INIT; q_d = '0;
        if (pc_q == 4'd11) begin
          pc_d = '0;
          if (pr_q == 4'd11) begin
            pr_d = '0;
            ch_d = (ch_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_q + 3'd1;
          end else pr_d = pr_q + 4'd1;
        end else pc_d = pc_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q <= '0; pr_q <= '0; pc_q <= '0; q_q <= '0;
      kr_q <= '0; kc_q <= '0; acc_q <= '0; max_q <= '0;
    end else begin
      ch_q <= ch_d; pr_q <= pr_d; pc_q <= pc_d; q_q <= q_d;
      kr_q <= kr_d; kc_q <= kc_d; acc_q <= acc_d; max_q <= max_d;
    end
  end

endmodule

// File: doc/conv_pool_engine.md
# conv_pool_engine

Sequential convolution + max-pool stage directly downstream of `read_data`.
- Consumes the 28×28 image and the eight 5×5 conv kernels that `read_data` holds.
- For each kernel in turn, computes the 5×5 valid convolution (24×24), an optional ReLU and a 2×2/stride-2 max-pool (12×12).
- Streams the 8×144 = 1152 pooled results in fc-weight order, so the FC stage can dot them directly against `fc_weight_n[0..1151]`.

## Interface

Parameters:
- `FRAC_BITS`, 16: fixed-point fraction bits of the weights; the product sum is arithmetically shifted right by this amount.
- `NUM_CH`, 8: number of kernels processed per run.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled in IDLE only.
- `data` in [31:0] [27:0][27:0]: image pixels, unsigned.
- `kernel` in signed [31:0] [5:0][5:0]: kernel selected by `ch_sel`; only [4:0][4:0] is used. The parent muxes `weight_{ch_sel+1}` onto this port combinationally.
- `ch_sel` out 3: current kernel index, 0..NUM_CH-1.
- `out_data` out signed 32: pooled result.
- `out_idx` out 11: result index = ch·144 + pr·12 + pc.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result is accepted.

## Operation

State machine: IDLE → MAC → CMP → (MAC | OUT) → (MAC | DONE) → IDLE.
- Counters: `ch` (0..NUM_CH-1), `pr`/`pc` (0..11), window `q` (0..3), tap `k` (0..24).
- IDLE: when `start`=1, clear all counters, clear the accumulator, set max = 0x80000000, go to MAC.
- MAC: one tap per cycle for 25 cycles, k = kr·5 + kc.
  - row = 2·pr + q[1] + kr; col = 2·pc + q[0] + kc.
  - acc += {1'b0, data[row][col]} × kernel[kr][kc].
  - Signed 33×32 multiply; 64-bit signed accumulator that wraps silently.
  - After k=24, go to CMP.
- CMP, one cycle:
  - v = acc >>> FRAC_BITS, saturated to the signed 32-bit range.
  - ReLU applied to v (see Configuration).
  - max = (v > max) ? v : max, signed compare.
  - Clear acc and k.
  - If q<3: q++, go to MAC. Otherwise go to OUT.
- OUT:
  - `out_valid`=1; `out_data`=max; `out_idx` as defined above.
  - On `out_valid && out_ready`: reset max and q, advance pc → pr → ch.
  - If `out_idx` was 1151 (last of NUM_CH·144), go to DONE. Otherwise go to MAC.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`.

## Timing

- Reset values: `out_data`=0, `out_idx`=0, `ch_sel`=0, `out_valid`=0, `busy`=0, `done`=0. All counters and acc are 0; state is IDLE.
- `start` high at edge N: `busy`=1 from N+1; the first MAC cycle is N+1.
- Per result: 4×(25+1) = 104 compute cycles, then OUT for ≥1 cycle.
- With `out_ready` held at 1, results are spaced 105 cycles apart. The first `out_valid` rises 104 cycles after the start edge.
- `out_data` and `out_idx` stay stable while `out_valid`=1 and `out_ready`=0. `out_valid` does not drop until the result is accepted.
- `ch_sel` changes only on the edge where the result with pr=pc=11 is accepted.
  - The kernel input is sampled combinationally in MAC and must be valid one cycle after `ch_sel` changes.
- `done` asserts the cycle after the 1152nd handshake. `busy` falls together with `done`.
- With `out_ready`=1, a full run takes 1 + 1152·105 cycles.
- Reset asserted mid-run: immediately returns to reset values. No partial `done` pulse. A new `start` is required.
- The `data` and `kernel` inputs must be static for the duration of `busy`.

## Configuration

- `CONV_RELU_EN` defined: CMP applies v = (v < 0) ? 0 : v before the max-pool. All outputs are ≥ 0.
- Not defined: no ReLU. The max is taken over the raw saturated values, so negative outputs are possible.

## Test plan

- All pixels = 1, all kernels = 0x00010000 (1.0), `out_ready`=1 → 1152 results, each `out_data`=25, `out_idx` counting 0..1151. `done` is pulsed once at cycle 1+1152·105.
- Ramp image data[r][c]=c; kernel 0 has a single tap [0][0]=1.0, rest 0 → channel 0 result (pr,pc) = 2·pc+1 for every pr.
- All kernels = 0xFFFF0000 (−1.0), all pixels = 1 → every `out_data`=0 with `CONV_RELU_EN` defined, −25 without.
- Saturation: all pixels = 0xFFFFFFFF, all weights = 0x7FFFFFFF, FRAC_BITS=16 → every `out_data`=0x7FFFFFFF.
- Backpressure: hold `out_ready`=0 for 10 cycles on the first result → `out_valid` stays 1 and `out_data`/`out_idx`=0 stay stable. Exactly one handshake occurs on release, and the next result follows 104 cycles later.
- Assert `rst`=0 during result 300 → all outputs return to 0 asynchronously. `start` after release restarts from `out_idx`=0.
